// File: rtl/exe_stage_if.sv
// Purpose: ID/EXE inputs and EXE/MEM, redirect and overflow outputs of exe_stage.
//   master : pipeline side (drives ID/EXE fields and freeze, observes results)
//   slave  : exe_stage (consumes ID/EXE fields, drives registered results)
// Signals: freeze, flush_in, wb_en_in, mem_sig_in[1:0], br_type_in[1:0],
//          exe_cmd_in[3:0], val1, val2, reg2, pc_in, dest_in[4:0] ->
//          wb_en_out, mem_sig_out[1:0], alu_res_out, st_val_out, dest_out,
//          br_taken, br_addr, ovf_out
interface exe_stage_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;

  logic            freeze;
  logic            flush_in;
  logic            wb_en_in;
  logic [1:0]      mem_sig_in;
  logic [1:0]      br_type_in;
  logic [3:0]      exe_cmd_in;
  logic [XLEN-1:0] val1;
  logic [XLEN-1:0] val2;
  logic [XLEN-1:0] reg2;
  logic [XLEN-1:0] pc_in;
  logic [REGW-1:0] dest_in;

  logic            wb_en_out;
  logic [1:0]      mem_sig_out;
  logic [XLEN-1:0] alu_res_out;
  logic [XLEN-1:0] st_val_out;
  logic [REGW-1:0] dest_out;
  logic            br_taken;
  logic [XLEN-1:0] br_addr;
  logic            ovf_out;

  modport master (
    output freeze, flush_in, wb_en_in, mem_sig_in, br_type_in, exe_cmd_in,
           val1, val2, reg2, pc_in, dest_in,
    input  wb_en_out, mem_sig_out, alu_res_out, st_val_out, dest_out,
           br_taken, br_addr, ovf_out
  );

  modport slave (
    input  freeze, flush_in, wb_en_in, mem_sig_in, br_type_in, exe_cmd_in,
           val1, val2, reg2, pc_in, dest_in,
    output wb_en_out, mem_sig_out, alu_res_out, st_val_out, dest_out,
           br_taken, br_addr, ovf_out
  );
endinterface

// File: rtl/exe_stage.sv
// Purpose: execute stage -- ALU, branch resolution, EXE/MEM register and
//   wrong-path squashing via a shadow counter after each taken branch.
// Ports: clk (rising edge), rst (async, active-low), bus (exe_stage_if.slave).
// Parameters: BR_SHADOW (instructions squashed after a taken branch, 1..7),
//   PC_SHIFT (left shift applied to the branch offset).
// Optional feature macro: EXE_OVF_EN -- signed overflow detection on ADD/SUB
//   drops write-back and pulses ovf_out; when undefined ovf_out is tied 0.
module exe_stage #(
  parameter int unsigned BR_SHADOW = 2,
  parameter int unsigned PC_SHIFT  = 2
) (
  input  logic         clk,
  input  logic         rst,
  exe_stage_if.slave   bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned SHW  = 3;

  localparam logic [1:0] BR_BEZ = 2'b01;
  localparam logic [1:0] BR_BNE = 2'b10;
  localparam logic [1:0] BR_JMP = 2'b11;

  logic [XLEN-1:0] alu_c;
  logic [XLEN-1:0] target_c;
  logic [4:0]      sh_c;
  logic            kill_c;
  logic            taken_c;
  logic            ovf_c;

  logic            wb_en_q,   wb_en_d;
  logic [1:0]      mem_sig_q, mem_sig_d;
  logic [XLEN-1:0] alu_res_q, alu_res_d;
  logic [XLEN-1:0] st_val_q,  st_val_d;
  logic [REGW-1:0] dest_q,    dest_d;
  logic            br_taken_q, br_taken_d;
  logic [XLEN-1:0] br_addr_q, br_addr_d;
  logic [SHW-1:0]  shadow_q,  shadow_d;

  assign sh_c     = bus.val2[4:0];
  assign target_c = bus.pc_in + (bus.val2 << PC_SHIFT);
  assign kill_c   = bus.flush_in | (shadow_q != '0);

  // ALU
  always_comb begin
    alu_c = '0;
    case (bus.exe_cmd_in)
      4'b0000: alu_c = bus.val1 + bus.val2;
      4'b0010: alu_c = bus.val1 - bus.val2;
      4'b0100: alu_c = bus.val1 & bus.val2;
      4'b0101: alu_c = bus.val1 | bus.val2;
      4'b0110: alu_c = ~(bus.val1 | bus.val2);
      4'b0111: alu_c = bus.val1 ^ bus.val2;
      4'b1000: alu_c = bus.val1 << sh_c;
      4'b1001: alu_c = XLEN'($signed(bus.val1) >>> sh_c);
      4'b1010: alu_c = bus.val1 >> sh_c;
      default: alu_c = '0;
    endcase
  end

  // Branch resolution; a killed instruction never redirects
  always_comb begin
    taken_c = 1'b0;
    case (bus.br_type_in)
      BR_BEZ:  taken_c = (bus.val1 == '0);
      BR_BNE:  taken_c = (bus.val1 != bus.reg2);
      BR_JMP:  taken_c = 1'b1;
      default: taken_c = 1'b0;
    endcase
    taken_c = taken_c & ~kill_c;
  end

`ifdef EXE_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: operands' signs (after SUB negation) agree but the result's differs
  always_comb begin
    ovf_c = 1'b0;
    case (bus.exe_cmd_in)
      4'b0000: ovf_c = (bus.val1[XLEN-1] == bus.val2[XLEN-1]) &&
                       (alu_c[XLEN-1] != bus.val1[XLEN-1]);
      4'b0010: ovf_c = (bus.val1[XLEN-1] != bus.val2[XLEN-1]) &&
                       (alu_c[XLEN-1] != bus.val1[XLEN-1]);
      default: ovf_c = 1'b0;
    endcase
    ovf_c = ovf_c & ~kill_c;
  end

  // Pulse output: cleared while frozen so it is never repeated
  always_comb begin
    ovf_d = 1'b0;
    if (!bus.freeze) ovf_d = ovf_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  assign bus.ovf_out = ovf_q;
`else
  assign ovf_c       = 1'b0;
  assign bus.ovf_out = 1'b0;
`endif

  // Next state: hold everything on freeze, but drop the redirect pulse
  always_comb begin
    wb_en_d    = wb_en_q;
    mem_sig_d  = mem_sig_q;
    alu_res_d  = alu_res_q;
    st_val_d   = st_val_q;
    dest_d     = dest_q;
    br_taken_d = 1'b0;
    br_addr_d  = br_addr_q;
    shadow_d   = shadow_q;
    if (!bus.freeze) begin
      wb_en_d    = bus.wb_en_in & ~kill_c & ~ovf_c;
      mem_sig_d  = kill_c ? 2'b00 : bus.mem_sig_in;
      alu_res_d  = alu_c;
      st_val_d   = bus.reg2;
      dest_d     = bus.dest_in;
      br_taken_d = taken_c;
      if (taken_c)               br_addr_d = target_c;
      if (taken_c)               shadow_d  = SHW'(BR_SHADOW);
      else if (shadow_q != '0)   shadow_d  = shadow_q - SHW'(1);
      else                       shadow_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      mem_sig_q  <= '0;
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
      br_taken_q <= 1'b0;
      br_addr_q  <= '0;
      shadow_q   <= '0;
    end else begin
      wb_en_q    <= wb_en_d;
      mem_sig_q  <= mem_sig_d;
      alu_res_q  <= alu_res_d;
      st_val_q   <= st_val_d;
      dest_q     <= dest_d;
      br_taken_q <= br_taken_d;
      br_addr_q  <= br_addr_d;
      shadow_q   <= shadow_d;
    end
  end

  assign bus.wb_en_out   = wb_en_q;
  assign bus.mem_sig_out = mem_sig_q;
  assign bus.alu_res_out = alu_res_q;
  assign bus.st_val_out  = st_val_q;
  assign bus.dest_out    = dest_q;
  assign bus.br_taken    = br_taken_q;
  assign bus.br_addr     = br_addr_q;
endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed literal checks plus randomized traffic compared
// every falling edge against a behavioural model of the execute stage.
module tb_exe_stage;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  bit   cmp_en;

  exe_stage_if bus ();

  exe_stage #(.BR_SHADOW(2), .PC_SHIFT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic        m_wb;
  logic [1:0]  m_mem;
  logic [31:0] m_alu, m_st, m_addr;
  logic [4:0]  m_dest;
  logic        m_taken, m_ovf;
  int          m_squash_left;

  function automatic logic [31:0] ref_alu(input logic [3:0] cmd,
                                          input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint      sa;
    sh = int'(b[4:0]);
    sa = longint'($signed(a));
    case (cmd)
      4'd0:    return 32'(longint'(a) + longint'(b));
      4'd2:    return 32'(longint'(a) - longint'(b));
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return ~(a | b);
      4'd7:    return a ^ b;
      4'd8:    return 32'(longint'(a) * (longint'(1) << sh));
      4'd9:    return 32'(sa / (longint'(1) << sh) - ((sa < 0 && (sa % (longint'(1) << sh)) != 0) ? 1 : 0));
      4'd10:   return 32'(longint'(a) / (longint'(1) << sh));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [3:0] cmd,
                                   input logic [31:0] a, input logic [31:0] b);
    longint r;
    if (cmd == 4'd0)      r = longint'($signed(a)) + longint'($signed(b));
    else if (cmd == 4'd2) r = longint'($signed(a)) - longint'($signed(b));
    else                  return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  always @(posedge clk or negedge rst) begin
    logic killed, take, ovf;
    if (!rst) begin
      m_wb <= 0; m_mem <= 0; m_alu <= 0; m_st <= 0; m_dest <= 0;
      m_taken <= 0; m_addr <= 0; m_ovf <= 0; m_squash_left <= 0;
    end else if (bus.freeze) begin
      m_taken <= 0;
      m_ovf   <= 0;
    end else begin
      killed = bus.flush_in || (m_squash_left > 0);
      take   = !killed && ((bus.br_type_in == 2'd3) ||
                           (bus.br_type_in == 2'd1 && bus.val1 == 0) ||
                           (bus.br_type_in == 2'd2 && bus.val1 != bus.reg2));
`ifdef EXE_OVF_EN
      ovf = !killed && ref_ovf(bus.exe_cmd_in, bus.val1, bus.val2);
`else
      ovf = 1'b0;
`endif
      m_alu   <= ref_alu(bus.exe_cmd_in, bus.val1, bus.val2);
      m_st    <= bus.reg2;
      m_dest  <= bus.dest_in;
      m_wb    <= bus.wb_en_in && !killed && !ovf;
      m_mem   <= killed ? 2'b00 : bus.mem_sig_in;
      m_taken <= take;
      m_ovf   <= ovf;
      if (take) m_addr <= 32'(longint'(bus.pc_in) + longint'(bus.val2) * 4);
      m_squash_left <= take ? 2 : (m_squash_left > 0 ? m_squash_left - 1 : 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge once enabled
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_wb",    32'(bus.wb_en_out),   32'(m_wb));
      chk("m_mem",   32'(bus.mem_sig_out), 32'(m_mem));
      chk("m_alu",   bus.alu_res_out,      m_alu);
      chk("m_st",    bus.st_val_out,       m_st);
      chk("m_dest",  32'(bus.dest_out),    32'(m_dest));
      chk("m_taken", 32'(bus.br_taken),    32'(m_taken));
      chk("m_addr",  bus.br_addr,          m_addr);
      chk("m_ovf",   32'(bus.ovf_out),     32'(m_ovf));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic fr, input logic fl, input logic wb,
                        input logic [1:0] mem, input logic [1:0] br, input logic [3:0] cmd,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] r2,
                        input logic [31:0] pc, input logic [4:0] d);
    bus.freeze = fr; bus.flush_in = fl; bus.wb_en_in = wb; bus.mem_sig_in = mem;
    bus.br_type_in = br; bus.exe_cmd_in = cmd; bus.val1 = v1; bus.val2 = v2;
    bus.reg2 = r2; bus.pc_in = pc; bus.dest_in = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_wb(input logic [4:0] d);
    set_in(0, 0, 1, 2'b00, 2'b00, 4'b0000, 32'd2, 32'd3, 32'd0, 32'h0, d);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cmp_en = 0;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_wb",    32'(bus.wb_en_out), 32'd0);
    chk("rst_alu",   bus.alu_res_out,    32'd0);
    chk("rst_taken", 32'(bus.br_taken),  32'd0);
    chk("rst_addr",  bus.br_addr,        32'd0);
    chk("rst_ovf",   32'(bus.ovf_out),   32'd0);
    cmp_en = 1;
    rst = 1'b1;

    // ADD 5+7 -> 12
    set_in(0, 0, 1, 2'b00, 2'b00, 4'b0000, 32'd5, 32'd7, 32'd0, 32'h0, 5'd3);
    tick();
    chk("add_res",  bus.alu_res_out,    32'd12);
    chk("add_dest", 32'(bus.dest_out),  32'd3);
    chk("add_wb",   32'(bus.wb_en_out), 32'd1);

    // SRA / SRL
    set_in(0, 0, 1, 2'b00, 2'b00, 4'b1001, 32'h8000_0000, 32'd4, 32'd0, 32'h0, 5'd4);
    tick();
    chk("sra_res", bus.alu_res_out, 32'hF800_0000);
    set_in(0, 0, 1, 2'b00, 2'b00, 4'b1010, 32'h8000_0000, 32'd4, 32'd0, 32'h0, 5'd4);
    tick();
    chk("srl_res", bus.alu_res_out, 32'h0800_0000);

    // BEZ taken -> 0x10C, then two squashed ADDs and one live one
    set_in(0, 0, 0, 2'b00, 2'b01, 4'b0000, 32'd0, 32'd3, 32'd9, 32'h100, 5'd0);
    tick();
    chk("bez_taken", 32'(bus.br_taken), 32'd1);
    chk("bez_addr",  bus.br_addr,       32'h10C);
    add_wb(5'd5);
    tick();
    chk("bez_pulse", 32'(bus.br_taken),  32'd0);
    chk("bez_sq1",   32'(bus.wb_en_out), 32'd0);
    tick();
    chk("bez_sq2",   32'(bus.wb_en_out), 32'd0);
    tick();
    chk("bez_live",  32'(bus.wb_en_out), 32'd1);

    // BNE equal: not taken; flushed JMP: no redirect, no wb/mem
    set_in(0, 0, 1, 2'b00, 2'b10, 4'b0000, 32'd4, 32'd1, 32'd4, 32'h300, 5'd6);
    tick();
    chk("bne_eq", 32'(bus.br_taken), 32'd0);
    set_in(0, 1, 1, 2'b11, 2'b11, 4'b0000, 32'd1, 32'd1, 32'hABCD, 32'h400, 5'd6);
    tick();
    chk("fl_taken", 32'(bus.br_taken),    32'd0);
    chk("fl_wb",    32'(bus.wb_en_out),   32'd0);
    chk("fl_mem",   32'(bus.mem_sig_out), 32'd0);
    chk("fl_addr",  bus.br_addr,          32'h10C);
    add_wb(5'd7);
    tick();
    chk("fl_next_wb", 32'(bus.wb_en_out), 32'd1);

    // JMP taken, then frozen for 3 cycles, then squash 2
    set_in(0, 0, 0, 2'b00, 2'b11, 4'b0000, 32'd0, 32'h10, 32'd0, 32'h200, 5'd1);
    tick();
    chk("jmp_addr", bus.br_addr, 32'h240);
    set_in(1, 0, 1, 2'b01, 2'b00, 4'b0000, 32'd1, 32'd1, 32'd0, 32'h0, 5'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_taken", 32'(bus.br_taken),  32'd0);
      chk("frz_alu",   bus.alu_res_out,    32'h10);
      chk("frz_wb",    32'(bus.wb_en_out), 32'd0);
    end
    add_wb(5'd8);
    tick();
    chk("frz_sq1",  32'(bus.wb_en_out), 32'd0);
    tick();
    chk("frz_sq2",  32'(bus.wb_en_out), 32'd0);
    tick();
    chk("frz_live", 32'(bus.wb_en_out), 32'd1);

    // Reset in the middle of a shadow
    set_in(0, 0, 0, 2'b00, 2'b11, 4'b0000, 32'd0, 32'h1, 32'd0, 32'h500, 5'd1);
    tick();
    add_wb(5'd9);
    tick();
    rst = 1'b0;
    #1;
    chk("mrst_wb",   32'(bus.wb_en_out), 32'd0);
    chk("mrst_addr", bus.br_addr,        32'd0);
    chk("mrst_dest", 32'(bus.dest_out),  32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_live", 32'(bus.wb_en_out), 32'd1);
    chk("mrst_alu",  bus.alu_res_out,    32'd5);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] v1, r2;
      logic [1:0]  br;
      v1 = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      r2 = ($urandom_range(0, 2) == 0) ? v1 : 32'($urandom);
      br = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      set_in(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
             2'($urandom), br, 4'($urandom), v1, 32'($urandom), r2,
             32'($urandom), 5'($urandom));
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
